// File: rtl/hazard_scoreboard.sv
// Producer-side hazard scoreboard: tracks destination tags through EX/MEM/WB,
// detects load-use hazards, holds ID for a configurable count and counts stall cycles.
module hazard_scoreboard #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int STALL_CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [2:0]             id_rs1,
    input  logic [2:0]             id_rs2,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic [2:0]             id_rd,
    input  logic                   id_writes_rd,
    input  logic                   id_is_load,
    input  logic                   flush,
    output logic                   stall,
    output logic [2:0]             rd_ex,
    output logic [2:0]             rd_mem,
    output logic [2:0]             rd_wb,
    output logic                   wr_ex,
    output logic                   wr_mem,
    output logic                   wr_wb,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef struct packed {
        logic [2:0] rd;
        logic       wr;
        logic       ld;
    } entry_t;

    localparam entry_t     BUBBLE    = '{rd: 3'd0, wr: 1'b0, ld: 1'b0};
    localparam logic [1:0] HOLD_LOAD = 2'(LOAD_STALL_CYCLES - 1);
    localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    entry_t     ex_q, mem_q, wb_q;
    entry_t     ex_d;
    logic [1:0] hold_cnt, hold_nxt;
    logic       haz;
    logic       src1_hit, src2_hit;

    // Only a writing load sitting in EX can create a hazard; older loads are forwarded.
    always_comb begin
        src1_hit = id_uses_rs1 && (id_rs1 == ex_q.rd);
        src2_hit = id_uses_rs2 && (id_rs2 == ex_q.rd);
        haz      = id_valid && ex_q.wr && ex_q.ld && (src1_hit || src2_hit);
    end

    assign stall = (haz || (hold_cnt != 2'd0)) && !flush;

    always_comb begin
        hold_nxt = hold_cnt;
        ex_d     = BUBBLE;
        if (flush) begin
            hold_nxt = 2'd0;
        end else begin
            // The counter reloads only from zero, so a hazard during a countdown extends nothing.
            if (haz && (hold_cnt == 2'd0)) begin
                hold_nxt = HOLD_LOAD;
            end else if (hold_cnt != 2'd0) begin
                hold_nxt = hold_cnt - 2'd1;
            end
            if (!stall) begin
                ex_d = '{rd: id_rd,
                         wr: id_valid && id_writes_rd,
                         ld: id_valid && id_is_load};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q     <= BUBBLE;
            mem_q    <= BUBBLE;
            wb_q     <= BUBBLE;
            hold_cnt <= 2'd0;
        end else begin
            ex_q     <= ex_d;
            mem_q    <= ex_q;
            wb_q     <= mem_q;
            hold_cnt <= hold_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_ONE;
        end
    end

    assign rd_ex  = ex_q.rd;
    assign rd_mem = mem_q.rd;
    assign rd_wb  = wb_q.rd;
    assign wr_ex  = ex_q.wr;
    assign wr_mem = mem_q.wr;
    assign wr_wb  = wb_q.wr;

endmodule
